// File: rtl/controle_rega_zonas.sv
// controle_rega_zonas
// Multi-zone irrigation sequencer. The block validates the per-zone sprinkler
// (asp) and drip (got) requests against the system mode and the tank-fill
// valve. It then irrigates one zone at a time, serving the zones round-robin.
// Each zone gets a timed turn, followed by a dead time. Sensor-conflict,
// state and filling errors are latched until limpeza clears them.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   mef1[1:0]       system mode, irrigation enabled only at 2'b11
//   VE              tank-fill valve open
//   limpeza         synchronous clear of latched errors (set wins)
//   asp/got[N]      per-zone sprinkler / drip requests
//   rega_asp/got[N] valve drives, at most one bit high across both
//   zona_ativa      zone being irrigated, valid while ocupado
//   ocupado         FSM is irrigating
//   ciclo_fim       one-cycle pulse after a completed turn
//   erro_zona[N]    latched asp&got conflict per zone
//   erro_estado     latched request while mode is not 2'b11
//   erro_enchimento latched request while VE is open
//   erro            OR of all error flags
module controle_rega_zonas #(
  parameter int N_ZONAS = 4,
  parameter int CONT_W  = 8,
  parameter int T_REGA  = 100,
  parameter int T_PAUSA = 2,
  localparam int ZW     = ($clog2(N_ZONAS) < 1) ? 1 : $clog2(N_ZONAS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         mef1,
  input  logic               VE,
  input  logic               limpeza,
  input  logic [N_ZONAS-1:0] asp,
  input  logic [N_ZONAS-1:0] got,
  output logic [N_ZONAS-1:0] rega_asp,
  output logic [N_ZONAS-1:0] rega_got,
  output logic [ZW-1:0]      zona_ativa,
  output logic               ocupado,
  output logic               ciclo_fim,
  output logic [N_ZONAS-1:0] erro_zona,
  output logic               erro_estado,
  output logic               erro_enchimento,
  output logic               erro
);

  typedef enum logic [1:0] {OCIOSO, REGANDO, PAUSA} estado_t;

  estado_t             state_reg, state_next;
  logic [CONT_W-1:0]   cont_reg, cont_next;
  logic [ZW-1:0]       ptr_reg, ptr_next;
  logic [ZW-1:0]       zona_reg, zona_next;
  logic                modo_reg, modo_next;   // 1 = sprinkler, 0 = drip

  logic [N_ZONAS-1:0]  rega_asp_reg, rega_asp_next;
  logic [N_ZONAS-1:0]  rega_got_reg, rega_got_next;
  logic                ocupado_reg, ocupado_next;
  logic                fim_reg, fim_next;
  logic [N_ZONAS-1:0]  erro_zona_reg, erro_zona_next;
  logic                erro_estado_reg, erro_estado_next;
  logic                erro_ench_reg, erro_ench_next;
  logic                erro_reg, erro_next;

  logic [N_ZONAS-1:0]  eligible;
  logic                any_req;
  logic                modo_ok;
  logic                start_ok;
  logic                found;
  logic [ZW-1:0]       sel;
  logic [ZW:0]         soma;
  logic [ZW-1:0]       zona_inc;
  logic                req_z;
  logic                conflito_z;
  logic                sai_turno;

  assign any_req  = |(asp | got);
  assign modo_ok  = (mef1 == 2'b11);
  assign start_ok = modo_ok & ~VE & ~erro_estado_reg & ~erro_ench_reg;

  // Per-zone conflict latches and eligibility. Eligibility looks at the
  // registered conflict flag, so a zone that conflicted earlier stays out
  // until it is explicitly cleared.
  generate
    for (genvar gi = 0; gi < N_ZONAS; gi++) begin : g_zona
      assign erro_zona_next[gi] = (asp[gi] & got[gi]) |
                                  (erro_zona_reg[gi] & ~limpeza);
      assign eligible[gi]       = (asp[gi] ^ got[gi]) & ~erro_zona_reg[gi];
    end
  endgenerate

  assign erro_estado_next = (~modo_ok & any_req) | (erro_estado_reg & ~limpeza);
  assign erro_ench_next   = (VE & any_req) | (erro_ench_reg & ~limpeza);
  assign erro_next        = (|erro_zona_next) | erro_estado_next | erro_ench_next;

  // First eligible zone at or after ptr, wrapping around. Because ptr < N and
  // k < N, a single conditional subtract is enough for the modulo.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    soma  = '0;
    for (int k = 0; k < N_ZONAS; k++) begin
      soma = {1'b0, ptr_reg} + (ZW+1)'(k);
      if (soma >= (ZW+1)'(N_ZONAS)) begin
        soma = soma - (ZW+1)'(N_ZONAS);
      end
      if (!found && eligible[soma[ZW-1:0]]) begin
        found = 1'b1;
        sel   = soma[ZW-1:0];
      end
    end
  end

  assign zona_inc   = (zona_reg == ZW'(N_ZONAS - 1)) ? '0 : zona_reg + 1'b1;
  assign req_z      = modo_reg ? asp[zona_reg] : got[zona_reg];
  assign conflito_z = asp[zona_reg] & got[zona_reg];

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cont_next  = cont_reg;
    ptr_next   = ptr_reg;
    zona_next  = zona_reg;
    modo_next  = modo_reg;
    fim_next   = 1'b0;
    sai_turno  = 1'b0;

    case (state_reg)
      OCIOSO: begin
        if (start_ok && found) begin
          state_next = REGANDO;
          zona_next  = sel;
          modo_next  = asp[sel];
          cont_next  = CONT_W'(T_REGA - 1);
        end
      end

      REGANDO: begin
        cont_next = cont_reg - 1'b1;
        if (!modo_ok || VE) begin
          // An abort skips the dead time.
          state_next = OCIOSO;
          ptr_next   = zona_inc;
        end else if (conflito_z || !req_z) begin
          sai_turno = 1'b1;
        end else if (cont_reg == '0) begin
          sai_turno = 1'b1;
          fim_next  = 1'b1;
        end

        if (sai_turno) begin
          ptr_next = zona_inc;
          if (T_PAUSA == 0) begin
            state_next = OCIOSO;
          end else begin
            state_next = PAUSA;
            cont_next  = CONT_W'(T_PAUSA - 1);
          end
        end
      end

      PAUSA: begin
        if (cont_reg == '0) begin
          state_next = OCIOSO;
        end else begin
          cont_next = cont_reg - 1'b1;
        end
      end

      default: state_next = OCIOSO;
    endcase
  end

  // Valve drives are derived from the next state, so they are registered
  // together with the state transition.
  always_comb begin
    rega_asp_next = '0;
    rega_got_next = '0;
    ocupado_next  = (state_next == REGANDO);
    if (state_next == REGANDO) begin
      if (modo_next) begin
        rega_asp_next[zona_next] = 1'b1;
      end else begin
        rega_got_next[zona_next] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= OCIOSO;
      cont_reg        <= '0;
      ptr_reg         <= '0;
      zona_reg        <= '0;
      modo_reg        <= 1'b0;
      rega_asp_reg    <= '0;
      rega_got_reg    <= '0;
      ocupado_reg     <= 1'b0;
      fim_reg         <= 1'b0;
      erro_zona_reg   <= '0;
      erro_estado_reg <= 1'b0;
      erro_ench_reg   <= 1'b0;
      erro_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cont_reg        <= cont_next;
      ptr_reg         <= ptr_next;
      zona_reg        <= zona_next;
      modo_reg        <= modo_next;
      rega_asp_reg    <= rega_asp_next;
      rega_got_reg    <= rega_got_next;
      ocupado_reg     <= ocupado_next;
      fim_reg         <= fim_next;
      erro_zona_reg   <= erro_zona_next;
      erro_estado_reg <= erro_estado_next;
      erro_ench_reg   <= erro_ench_next;
      erro_reg        <= erro_next;
    end
  end

  assign rega_asp        = rega_asp_reg;
  assign rega_got        = rega_got_reg;
  assign zona_ativa      = zona_reg;
  assign ocupado         = ocupado_reg;
  assign ciclo_fim       = fim_reg;
  assign erro_zona       = erro_zona_reg;
  assign erro_estado     = erro_estado_reg;
  assign erro_enchimento = erro_ench_reg;
  assign erro            = erro_reg;

endmodule

// File: doc/controle_rega_zonas.md
# controle_rega_zonas

Multi-zone irrigation sequencer that generalises the single-channel sprinkler/drip validator to `N_ZONAS` zones. It validates per-zone sprinkler (`asp`) and drip (`got`) requests against the system mode (`mef1`) and the tank-fill valve (`VE`), then irrigates one zone at a time. Zones are served round-robin, each for a timed interval, with a dead time between zones. It latches sensor-conflict, state and filling errors until `limpeza` clears them. The block sits between the main system FSM and the zone valve drivers.

## Interface
- `N_ZONAS`, 4: number of zones, ≥2.
- `CONT_W`, 8: width of the internal duration counter.
- `T_REGA`, 100: irrigation cycles per zone turn; 1 ≤ `T_REGA` < 2^`CONT_W`.
- `T_PAUSA`, 2: dead cycles after each zone turn; 0 ≤ `T_PAUSA` < 2^`CONT_W`.

- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mef1` in 2: system mode; irrigation is enabled only when `mef1` = 2'b11.
- `VE` in 1: tank-fill valve open.
- `limpeza` in 1: synchronous clear of all latched errors.
- `asp` in N_ZONAS: per-zone sprinkler request.
- `got` in N_ZONAS: per-zone drip request.
- `rega_asp` out N_ZONAS: sprinkler valve drive; at most one bit high.
- `rega_got` out N_ZONAS: drip valve drive; at most one bit high, and never in the same cycle as any `rega_asp` bit.
- `zona_ativa` out max(1,$clog2(N_ZONAS)): index of the zone being irrigated; valid while `ocupado`.
- `ocupado` out 1: FSM is in REGANDO.
- `ciclo_fim` out 1: one-cycle pulse on normal completion of a zone turn.
- `erro_zona` out N_ZONAS: latched sensor conflict per zone (`asp[i]` & `got[i]`).
- `erro_estado` out 1: latched; a request was present while `mef1` ≠ 2'b11.
- `erro_enchimento` out 1: latched; `VE` = 1 while any request is present.
- `erro` out 1: OR of all error flags.

## Operation
- All outputs are registered. On reset, every output is 0, the FSM is in OCIOSO, the counter is 0, and the round-robin pointer `ptr` is 0.
- Error latches are evaluated every cycle in every state:
  - Set on the sampled condition.
  - `limpeza` clears them; set wins over clear in the same cycle.
- A zone i is eligible when `asp[i]` XOR `got[i]` = 1 and `erro_zona[i]` = 0.
- A start is allowed when all of these hold: `mef1` = 2'b11, `VE` = 0, `erro_estado` = 0 and `erro_enchimento` = 0.
- **OCIOSO:** all valve outputs are 0. If a start is allowed and any zone is eligible:
  - Select the first eligible zone searching from `ptr` upward, wrapping mod N_ZONAS.
  - Load `zona_ativa` and latch the mode (asp or got).
  - Load the counter with `T_REGA`-1 and go to REGANDO.
- **REGANDO:** drive `rega_asp[z]` or `rega_got[z]` according to the latched mode. Decrement the counter each cycle. Exit priority, highest first:
  1. `mef1` ≠ 2'b11 or `VE` = 1 → OCIOSO. The matching error latch sets if any request is present.
  2. `asp[z]` & `got[z]` → PAUSA; `erro_zona[z]` sets.
  3. The latched mode's request for zone z drops → PAUSA; no `ciclo_fim`.
  4. Counter = 0 → PAUSA; `ciclo_fim` = 1.
- On every exit from REGANDO, `ptr` ← (z+1) mod N_ZONAS.
- **PAUSA:** all valve outputs are 0 for `T_PAUSA` cycles, then the FSM goes to OCIOSO. If `T_PAUSA` = 0, the FSM goes straight from REGANDO to OCIOSO.
- Requests are never queued; eligibility is re-evaluated each time the FSM is in OCIOSO.

## Timing
- Start: eligibility is sampled at edge E0. At E0, `rega_*[z]` and `ocupado` rise. They stay high exactly `T_REGA` cycles and fall at edge E0+`T_REGA`.
- `ciclo_fim` is high for the single cycle following edge E0+`T_REGA`.
- Zone-to-zone gap: the next valve rises at edge E0+`T_REGA`+`T_PAUSA`+1, giving `T_PAUSA`+1 low cycles between turns.
- Abort: the condition is sampled at edge Ek, and the valve outputs and `ocupado` are 0 from Ek.
- Error latches assert at the edge that samples the condition, so there is one cycle of latency from an input change.
- `reset_n` low mid-operation forces all outputs to 0 immediately, without waiting for a clock edge.

## Test plan
- **Reset:** assert `reset_n` = 0 with random inputs → all outputs 0, including `zona_ativa` = 0.
- **Round-robin sequencing:** `T_REGA` = 4, `T_PAUSA` = 2; hold `mef1` = 2'b11, `asp[1]` = 1, `got[2]` = 1.
  - `rega_asp[1]` is high for 4 cycles, then `ciclo_fim` pulses.
  - After 3 low cycles, `rega_got[2]` is high for 4 cycles.
  - The sequence then returns to zone 1.
- **Sensor conflict:** `asp[0]` = `got[0]` = 1 alongside `asp[3]` = 1.
  - `erro_zona[0]` = 1 and `erro` = 1 one cycle later.
  - Zone 0 is never driven; zone 3 keeps cycling.
  - Drop the conflict and pulse `limpeza` → `erro_zona[0]` = 0, and zone 0 is then served.
- **Tank filling mid-turn:** `VE` = 1 at the 2nd REGANDO cycle.
  - Valve and `ocupado` are 0 from that edge, and `erro_enchimento` = 1.
  - No start occurs until `VE` = 0 and `limpeza` is applied.
- **Mode drop:** `mef1` changes to 2'b00 mid-turn with requests still held.
  - Outputs turn off and `erro_estado` = 1.
  - Outputs stay off until `mef1` = 2'b11 and `limpeza` is applied.
- **Reset mid-turn:** assert `reset_n` = 0 during REGANDO → `rega_*` is 0 with no clock edge. After release, service restarts from zone 0.
